riscv_irq_arbiter: RTL and testbench

//  Interrupt-source side of the core IRQ interface: collects event pulses into sticky pending bits and applies a mask.

---
 rtl/riscv_irq_arbiter_pkg.sv | 18 +
 rtl/riscv_irq_prio_enc.sv | 26 ++
 rtl/riscv_irq_arbiter.sv | 136 +++++++++++++
 tb/tb_riscv_irq_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_irq_arbiter_pkg.sv
// Shared constants for the interrupt arbiter slice.
//  - Fixed interrupt ids of the standard software/timer/external/fast lines.
//  - Arbiter FSM state encoding (plain constants for legacy tool compatibility).
package riscv_irq_arbiter_pkg;

    localparam int unsigned IRQ_ID_SW        = 3;
    localparam int unsigned IRQ_ID_TIMER     = 7;
    localparam int unsigned IRQ_ID_EXT       = 11;
    localparam int unsigned IRQ_ID_FAST_BASE = 16;
    localparam int unsigned IRQ_NUM_FAST     = 15;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_REQ  = 2'd1;
    localparam arb_state_t ARB_GAP  = 2'd2;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// MSB-first find-first-one over a request vector (combinational).
// Ports:
//  req    in   WIDTH  request bits
//  valid  out  1      any request set
//  id     out  5      index of the highest set request bit (0 when none)
module riscv_irq_prio_enc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [4:0]       id
);

    // Ascending scan: the last hit is the highest index.
    always_comb begin
        valid = 1'b0;
        id    = 5'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 5'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Interrupt-source side of the core IRQ interface. Event pulses set sticky pending bits,
// a mask selects active ones, and the highest active id is presented to the core as a
// level request held until acked or withdrawn.
// Ports:
//  clk, rst                   clock, async active-high reset
//  event_i, pend_set_i        set terms for the pending bits
//  pend_clr_i                 software clear of pending bits
//  mask_we_i, mask_wdata_i    mask register write
//  pending_o, mask_o          register readback
//  irq_o, irq_id_o, irq_sec_o request to the core
//  irq_ack_i, irq_ack_id_i    ack from the core, clears pending[irq_ack_id_i]
//  irq_software_o/timer/external/fast  masked pending bits on the standard lines
module riscv_irq_arbiter
    import riscv_irq_arbiter_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 32,
    parameter int unsigned PULP_SECURE = 0,
    parameter logic [31:0] SEC_MASK    = 32'h0,
    parameter logic [31:0] MASK_RST    = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] event_i,
    input  logic [NUM_IRQ-1:0] pend_set_i,
    input  logic [NUM_IRQ-1:0] pend_clr_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic [NUM_IRQ-1:0] mask_o,
    output logic               irq_o,
    output logic [4:0]         irq_id_o,
    output logic               irq_sec_o,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_ack_id_i,
    output logic               irq_software_o,
    output logic               irq_timer_o,
    output logic               irq_external_o,
    output logic [14:0]        irq_fast_o
);

    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] act;
    logic [31:0]        act_ext;
    logic               win_valid;
    logic [4:0]         win_id;
    arb_state_t         state_q, state_d;
    logic [4:0]         id_q, id_d;
    logic               sec_q, sec_d;

    // Ack ids with no matching bit (>= NUM_IRQ) decode to nothing.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = irq_ack_i && (irq_ack_id_i == 5'(i));
        end
    end

    // Set is applied after clear so a simultaneous event is never lost.
    assign pending_d = (pending_q & ~(pend_clr_i | ack_clr)) | event_i | pend_set_i;

    assign act = pending_q & mask_q;

    // Zero-extended view so the fixed-id lines read 0 for ids that do not exist.
    always_comb begin
        act_ext              = 32'h0;
        act_ext[NUM_IRQ-1:0] = act;
    end

    riscv_irq_prio_enc #(
        .WIDTH (NUM_IRQ)
    ) u_prio_enc (
        .req   (act),
        .valid (win_valid),
        .id    (win_id)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        sec_d   = sec_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_d = ARB_REQ;
                    id_d    = win_id;
                    sec_d   = (PULP_SECURE != 0) ? SEC_MASK[win_id] : 1'b0;
                end
            end
            ARB_REQ: begin
                // id/sec stay frozen while requesting; only ack or withdraw leave.
                if (irq_ack_i) begin
                    state_d = ARB_GAP;
                end else if (!act_ext[id_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GAP:  state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= MASK_RST[NUM_IRQ-1:0];
            state_q   <= ARB_IDLE;
            id_q      <= 5'd0;
            sec_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (mask_we_i) begin
                mask_q <= mask_wdata_i;
            end
            state_q <= state_d;
            id_q    <= id_d;
            sec_q   <= sec_d;
        end
    end

    assign pending_o      = pending_q;
    assign mask_o         = mask_q;
    assign irq_o          = (state_q == ARB_REQ);
    assign irq_id_o       = id_q;
    assign irq_sec_o      = sec_q;
    assign irq_software_o = act_ext[IRQ_ID_SW];
    assign irq_timer_o    = act_ext[IRQ_ID_TIMER];
    assign irq_external_o = act_ext[IRQ_ID_EXT];
    assign irq_fast_o     = act_ext[IRQ_ID_FAST_BASE +: IRQ_NUM_FAST];

    // An ack outside REQ is a core protocol error (it still clears pending).
    ack_in_req_a: assert property (@(posedge clk) disable iff (rst)
        irq_ack_i |-> (state_q == ARB_REQ));

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
module tb_riscv_irq_arbiter;

    localparam logic [31:0] MRST = 32'h0000_0F0F;

    logic        clk;
    logic        rst;
    logic [31:0] event_i, pend_set_i, pend_clr_i, mask_wdata_i;
    logic        mask_we_i;
    logic [31:0] pending_o, mask_o;
    logic        irq_o, irq_sec_o, irq_ack_i;
    logic [4:0]  irq_id_o, irq_ack_id_i;
    logic        irq_software_o, irq_timer_o, irq_external_o;
    logic [14:0] irq_fast_o;

    int nvec = 0;
    int nerr = 0;

    riscv_irq_arbiter #(
        .NUM_IRQ     (32),
        .PULP_SECURE (1),
        .SEC_MASK    (32'h0001_0000),
        .MASK_RST    (MRST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .event_i        (event_i),
        .pend_set_i     (pend_set_i),
        .pend_clr_i     (pend_clr_i),
        .mask_we_i      (mask_we_i),
        .mask_wdata_i   (mask_wdata_i),
        .pending_o      (pending_o),
        .mask_o         (mask_o),
        .irq_o          (irq_o),
        .irq_id_o       (irq_id_o),
        .irq_sec_o      (irq_sec_o),
        .irq_ack_i      (irq_ack_i),
        .irq_ack_id_i   (irq_ack_id_i),
        .irq_software_o (irq_software_o),
        .irq_timer_o    (irq_timer_o),
        .irq_external_o (irq_external_o),
        .irq_fast_o     (irq_fast_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per cycle: inputs driven during the cycle, outputs expected during it.
    typedef struct {
        logic [31:0] ev;
        logic [31:0] set;
        logic [31:0] clr;
        logic        mwe;
        logic [31:0] mwd;
        logic        ack;
        logic [4:0]  aid;
        logic        eirq;
        logic [4:0]  eid;
        logic [31:0] epend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic [31:0] ev, input logic [31:0] set,
                                 input logic [31:0] clr, input logic mwe,
                                 input logic [31:0] mwd, input logic ack,
                                 input logic [4:0] aid, input logic eirq,
                                 input logic [4:0] eid, input logic [31:0] epend);
        vec_t r;
        r.ev = ev; r.set = set; r.clr = clr; r.mwe = mwe; r.mwd = mwd;
        r.ack = ack; r.aid = aid; r.eirq = eirq; r.eid = eid; r.epend = epend;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ev, input logic ack, input logic [4:0] aid);
        event_i      = ev;
        pend_set_i   = 32'h0;
        pend_clr_i   = 32'h0;
        mask_we_i    = 1'b0;
        mask_wdata_i = 32'h0;
        irq_ack_i    = ack;
        irq_ack_id_i = aid;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 1'b0, 5'd0);

        // mask / event / ack / check columns
        tbl.push_back(row(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));          // r0 mask all
        tbl.push_back(row(32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0));                  // r1 event 5
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h20));                  // irq at +2
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h20));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 5, 1, 5, 32'h20));                  // ack 5
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 5, 0));                       // GAP
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
        tbl.push_back(row(32'h0010_0008, 0, 0, 0, 0, 0, 0, 0, 5, 0));           // r8 ev 3,20
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h0010_0008));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 20, 32'h0010_0008));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 20, 1, 20, 32'h0010_0008));         // ack 20
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 20, 32'h8));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 20, 32'h8));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h8));                   // ack+3
        tbl.push_back(row(32'h8, 0, 0, 0, 0, 1, 3, 1, 3, 32'h8));               // ev+ack 3
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h8));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h8));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h8));                   // re-presented
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 3, 1, 3, 32'h8));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(row(32'h200, 0, 0, 0, 0, 0, 0, 0, 3, 0));                 // r21 ev 9
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h200));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h200));
        tbl.push_back(row(0, 0, 0, 1, 32'hFFFF_FDFF, 0, 0, 1, 9, 32'h200));     // mask 9 off
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h200));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h200));                 // withdrawn
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h200));
        tbl.push_back(row(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 9, 32'h200));     // r28 unmask
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h200));
        tbl.push_back(row(32'h0200_0000, 0, 0, 0, 0, 0, 0, 1, 9, 32'h200));     // ev 25 in REQ
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h0200_0200));           // id frozen
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 9, 1, 9, 32'h0200_0200));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h0200_0000));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h0200_0000));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 25, 32'h0200_0000));
        tbl.push_back(row(0, 0, 32'h0200_0000, 0, 0, 0, 0, 1, 25, 32'h0200_0000)); // sw clr
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 25, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 25, 0));                      // withdrawn
        tbl.push_back(row(0, 32'h2, 0, 0, 0, 0, 0, 0, 25, 0));                  // r39 sw set 1
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 25, 32'h2));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h2));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));                       // back to IDLE

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pending", pending_o, 32'h0);
        chk("rst_mask", mask_o, MRST);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_id", 32'(irq_id_o), 32'h0);
        chk("rst_sec", 32'(irq_sec_o), 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            chk($sformatf("r%0d_irq", i), 32'(irq_o), 32'(tbl[i].eirq));
            chk($sformatf("r%0d_id", i), 32'(irq_id_o), 32'(tbl[i].eid));
            chk($sformatf("r%0d_pend", i), pending_o, tbl[i].epend);
            event_i      = tbl[i].ev;
            pend_set_i   = tbl[i].set;
            pend_clr_i   = tbl[i].clr;
            mask_we_i    = tbl[i].mwe;
            mask_wdata_i = tbl[i].mwd;
            irq_ack_i    = tbl[i].ack;
            irq_ack_id_i = tbl[i].aid;
        end
        @(negedge clk);
        drive(32'h0, 1'b0, 5'd0);

        // Secure attribute and fast lines: id 16 is secure, id 17 is not.
        @(negedge clk);
        drive(32'h0001_0000, 1'b0, 5'd0);
        @(negedge clk);
        drive(32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("sec16_irq", 32'(irq_o), 32'h1);
        chk("sec16_id", 32'(irq_id_o), 32'd16);
        chk("sec16_sec", 32'(irq_sec_o), 32'h1);
        chk("sec16_fast", 32'(irq_fast_o), 32'h1);
        drive(32'h0, 1'b1, 5'd16);
        @(negedge clk);
        drive(32'h0, 1'b0, 5'd0);
        chk("sec16_gap", 32'(irq_o), 32'h0);
        @(negedge clk);
        drive(32'h0002_0000, 1'b0, 5'd0);
        @(negedge clk);
        drive(32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("sec17_id", 32'(irq_id_o), 32'd17);
        chk("sec17_sec", 32'(irq_sec_o), 32'h0);
        chk("sec17_fast", 32'(irq_fast_o), 32'h2);
        drive(32'h0, 1'b1, 5'd17);
        @(negedge clk);
        drive(32'h0, 1'b0, 5'd0);
        @(negedge clk);

        // Standard lines: sw/timer/ext together, highest (11) presented.
        drive(32'h0000_0888, 1'b0, 5'd0);
        @(negedge clk);
        drive(32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("std_sw", 32'(irq_software_o), 32'h1);
        chk("std_timer", 32'(irq_timer_o), 32'h1);
        chk("std_ext", 32'(irq_external_o), 32'h1);
        chk("std_id", 32'(irq_id_o), 32'd11);
        chk("std_irq", 32'(irq_o), 32'h1);

        // Asynchronous reset mid-request, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("arst_irq", 32'(irq_o), 32'h0);
        chk("arst_pending", pending_o, 32'h0);
        chk("arst_id", 32'(irq_id_o), 32'h0);
        chk("arst_mask", mask_o, MRST);
        chk("arst_ext", 32'(irq_external_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_irq", 32'(irq_o), 32'h0);
        chk("post_rst_pending", pending_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
